// File: rtl/bus_timer_slave.sv
// ============================================================================
//  Module      : bus_timer_slave
//  Description : Bus-slave timer/compare peripheral with wait-state responder,
//                prescaled 32-bit counter, compare match flag and level irq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timer_slave #(
    parameter int WAIT_STATES = 0,
    parameter int PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq
);

    localparam int             PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  C_PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [3:0]     C_WAIT      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [1:0]     sel_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;

    logic [2:0]     ctrl_q, ctrl_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    cmp_q, cmp_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           match_q, match_d;
    logic [PW-1:0]  presc_q, presc_d;

    logic           w_commit;
    logic [1:0]     w_sel;
    logic           w_we;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_mask;
    logic [31:0]    w_rmux;
    logic           w_tick;
    logic           w_hit;
    logic           w_unused_addr;

    assign w_unused_addr = ^{addr[31:4], addr[1:0]};

    // With zero wait states the commit edge is the capture edge, so the live bus is used.
    assign w_sel   = (state_q == S_IDLE) ? addr[3:2] : sel_q;
    assign w_we    = (state_q == S_IDLE) ? we        : we_q;
    assign w_be    = (state_q == S_IDLE) ? be        : be_q;
    assign w_wdata = (state_q == S_IDLE) ? wdata     : wdata_q;
    assign w_mask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wcnt_d = C_WAIT;
                    if (C_WAIT == 4'd0) begin
                        state_d  = S_ACK;
                        w_commit = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q <= 4'd1) begin
                    state_d  = S_ACK;
                    w_commit = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (w_sel)
            2'd0:    w_rmux = {29'd0, ctrl_q};
            2'd1:    w_rmux = count_q;
            2'd2:    w_rmux = cmp_q;
            default: w_rmux = {31'd0, match_q};
        endcase
    end

    assign w_tick = ctrl_q[0] && (presc_q == C_PRESC_MAX);
    assign w_hit  = w_tick && (count_q == cmp_q);

    always_comb begin
        ctrl_d  = ctrl_q;
        cmp_d   = cmp_q;
        rdata_d = rdata_q;
        match_d = match_q | w_hit;
        presc_d = (ctrl_q[0] && !w_tick) ? presc_q + PW'(1) : '0;
        count_d = count_q;
        if (w_tick) begin
            count_d = (w_hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end
        if (w_commit && !w_we) begin
            rdata_d = w_rmux;
        end
        // Bus writes are applied last so a COUNT write overrides the tick update.
        if (w_commit && w_we) begin
            case (w_sel)
                2'd0: ctrl_d = (ctrl_q & ~w_mask[2:0]) | (w_wdata[2:0] & w_mask[2:0]);
                2'd1: begin
                    count_d = (count_q & ~w_mask) | (w_wdata & w_mask);
                    presc_d = '0;
                end
                2'd2: cmp_d = (cmp_q & ~w_mask) | (w_wdata & w_mask);
                default: begin
                    if (w_be[0] && w_wdata[0]) begin
                        match_d = w_hit;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            sel_q   <= 2'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            ctrl_q  <= 3'd0;
            count_q <= 32'd0;
            cmp_q   <= 32'd0;
            rdata_q <= 32'd0;
            match_q <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_IDLE && req) begin
                sel_q   <= addr[3:2];
                we_q    <= we;
                be_q    <= be;
                wdata_q <= wdata;
            end
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            rdata_q <= rdata_d;
            match_q <= match_d;
            presc_q <= presc_d;
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state_q == S_ACK);
    assign irq   = match_q & ctrl_q[2];

endmodule

`default_nettype wire

// File: tb/tb_bus_timer_slave.sv
// ============================================================================
//  Module      : tb_bus_timer_slave
//  Description : Directed bench for bus_timer_slave with an edge-indexed
//                reference model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_timer_slave;

    localparam int WS = 2;
    localparam int PS = 1;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    bus_timer_slave #(.WAIT_STATES(WS), .PRESCALE(PS)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .addr  (addr),
        .wdata (wdata),
        .req   (req),
        .we    (we),
        .be    (be),
        .rdata (rdata),
        .ack   (ack),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Model keyed on absolute edge numbers: a request captured at edge e commits at e+WS,
    // acks in the following cycle, and the next capture is allowed from e+WS+2.
    typedef struct packed {
        logic [31:0] e;
        logic [31:0] free_e;
        logic [31:0] commit_e;
        logic        pend;
        logic [1:0]  a;
        logic        cwe;
        logic [3:0]  cbe;
        logic [31:0] cd;
        logic [2:0]  ctrl;
        logic [31:0] count;
        logic [31:0] cmp;
        logic [31:0] rdata;
        logic        match;
        logic        ack;
        logic [31:0] presc;
    } model_t;

    model_t m;

    function automatic model_t f_step(model_t s, logic i_req, logic i_we, logic [31:0] i_addr,
                                      logic [31:0] i_wdata, logic [3:0] i_be);
        model_t      n;
        logic        tick;
        logic        hit;
        logic [31:0] mask;
        n     = s;
        n.e   = s.e + 1;
        n.ack = 1'b0;
        if (!s.pend && i_req && n.e >= s.free_e) begin
            n.pend     = 1'b1;
            n.a        = i_addr[3:2];
            n.cwe      = i_we;
            n.cbe      = i_be;
            n.cd       = i_wdata;
            n.commit_e = n.e + WS;
        end
        tick    = s.ctrl[0] && (s.presc == PS - 1);
        hit     = tick && (s.count == s.cmp);
        n.presc = (s.ctrl[0] && !tick) ? s.presc + 1 : 0;
        if (tick) n.count = (hit && s.ctrl[1]) ? 32'd0 : s.count + 1;
        if (hit)  n.match = 1'b1;
        if (n.pend && n.commit_e == n.e) begin
            n.ack    = 1'b1;
            n.pend   = 1'b0;
            n.free_e = n.e + 2;
            mask = {{8{n.cbe[3]}}, {8{n.cbe[2]}}, {8{n.cbe[1]}}, {8{n.cbe[0]}}};
            if (!n.cwe) begin
                case (n.a)
                    2'd0:    n.rdata = {29'd0, s.ctrl};
                    2'd1:    n.rdata = s.count;
                    2'd2:    n.rdata = s.cmp;
                    default: n.rdata = {31'd0, s.match};
                endcase
            end else begin
                case (n.a)
                    2'd0: n.ctrl = (s.ctrl & ~mask[2:0]) | (n.cd[2:0] & mask[2:0]);
                    2'd1: begin
                        n.count = (s.count & ~mask) | (n.cd & mask);
                        n.presc = 0;
                    end
                    2'd2: n.cmp = (s.cmp & ~mask) | (n.cd & mask);
                    default: if (n.cbe[0] && n.cd[0]) n.match = hit;
                endcase
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= f_step(m, req, we, addr, wdata, be);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ack", {31'd0, ack}, {31'd0, m.ack});
        chk("rdata", rdata, m.rdata);
        chk("irq", {31'd0, irq}, {31'd0, m.match & m.ctrl[2]});
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd);
        int          lat;
        logic [31:0] junk;
        junk      = $urandom();
        junk[3:2] = a;
        req   = 1'b1;
        we    = w;
        addr  = junk;
        wdata = d;
        be    = b;
        lat   = 0;
        do begin
            step();
            lat++;
        end while (!ack && lat < 40);
        chk("xfer_latency", 32'(lat), 32'd3);
        rd  = rdata;
        req = 1'b0;
        we  = 1'b0;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] rd;
        xfer(1'b1, a, d, b, rd);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        xfer(1'b0, a, 32'd0, 4'hF, rd);
        chk(nm, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;
        rstn  = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        be    = 4'd0;
        repeat (3) step();
        rstn = 1'b1;
        step();

        // Reset in the middle of a wait period drops the write and never acks.
        req = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'h1234; be = 4'hF;
        step();
        step();
        rstn = 1'b0;
        chk("rst_ack_low", {31'd0, ack}, 32'd0);
        repeat (3) begin
            step();
            chk("rst_ack_hold", {31'd0, ack}, 32'd0);
        end
        req = 1'b0; we = 1'b0;
        rstn = 1'b1;
        step();
        chk("rst_rdata", rdata, 32'd0);
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_count", 2'd1, 32'd0);
        rd_chk("rst_cmp", 2'd2, 32'd0);
        rd_chk("rst_status", 2'd3, 32'd0);

        // Back-to-back reads with req held high.
        req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
        lat = 0;
        do begin step(); lat++; end while (!ack && lat < 40);
        chk("lat_first", 32'(lat), 32'd3);
        lat = 0;
        do begin step(); lat++; end while (!ack && lat < 40);
        chk("lat_second", 32'(lat), 32'd4);
        req = 1'b0;
        step();

        wr(2'd1, 32'hAABBCCDD, 4'b0101);
        rd_chk("be_count", 2'd1, 32'h00BB00DD);

        // Compare with auto-reload and irq.
        wr(2'd2, 32'd5, 4'hF);
        wr(2'd1, 32'd0, 4'hF);
        wr(2'd0, 32'h7, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            xfer(1'b0, 2'd3, 32'd0, 4'hF, rd);
            seen = rd[0];
        end
        chk("match_seen", {31'd0, seen}, 32'd1);
        chk("irq_on_match", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h4, 4'hF);
        xfer(1'b0, 2'd1, 32'd0, 4'hF, rd);
        chk("count_reloaded_range", {31'd0, (rd <= 32'd5)}, 32'd1);
        wr(2'd3, 32'h1, 4'b0010);
        chk("w1c_wrong_lane", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h1, 4'b0001);
        chk("w1c_irq_low", {31'd0, irq}, 32'd0);
        rd_chk("w1c_status", 2'd3, 32'd0);

        // Wrap from 0xFFFFFFFF: four ticks elapse between the two CTRL commits.
        wr(2'd0, 32'h0, 4'hF);
        wr(2'd2, 32'd3, 4'hF);
        wr(2'd1, 32'hFFFFFFFF, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        wr(2'd0, 32'h0, 4'hF);
        rd_chk("wrap_count", 2'd1, 32'd3);
        rd_chk("wrap_nomatch", 2'd3, 32'd0);

        // W1C collides with a new match; COUNT write collides with a tick.
        wr(2'd2, 32'd13, 4'hF);
        wr(2'd1, 32'd10, 4'hF);
        wr(2'd0, 32'h1, 4'hF);
        wr(2'd3, 32'h1, 4'hF);
        wr(2'd1, 32'h100, 4'hF);
        wr(2'd0, 32'h0, 4'hF);
        rd_chk("collide_match", 2'd3, 32'd1);
        rd_chk("collide_count", 2'd1, 32'h104);

        wr(2'd0, 32'hFFFFFFF8, 4'hF);
        rd_chk("ctrl_upper_ignored", 2'd0, 32'd0);
        wr(2'd0, 32'hFFFFFFFE, 4'b0001);
        rd_chk("ctrl_lane0", 2'd0, 32'd6);
        chk("irq_enable_late", {31'd0, irq}, 32'd1);
        wr(2'd2, 32'h11223344, 4'b1010);
        rd_chk("cmp_lanes", 2'd2, 32'h1100330D);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule

`default_nettype wire
